// File: rtl/silencer_sequencer.sv
// silencer_sequencer
//   Frame controller sitting in front of the silencer datapath. Each START pulse
//   streams DEPTH (intensity, phase) pairs from the drive memory to the silencer
//   as one uninterrupted DIN_VALID burst. Silencer settings are double-buffered:
//   CFG_UPDATE fills a pending shadow, and the shadow is copied to the active
//   outputs only in the LOAD state, so a burst never sees a settings change.
//   One early START is queued; a second one while queued is dropped and flagged.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   START               one-cycle frame request
//   CFG_UPDATE, CFG_*   strobe plus requested silencer settings
//   OVERRUN_CLR         clears the sticky OVERRUN flag
//   RD_EN, ADDR         drive-memory read request
//   RDATA_*             drive-memory read data, READ_LATENCY cycles after RD_EN
//   DIN_VALID, *_IN     sample stream to the silencer
//   UPDATE_RATE_*, COMPLETION_STEPS_*, FIXED_COMPLETION_STEPS
//                       active silencer settings
//   BUSY, FRAME_DONE, OVERRUN
//                       status
module silencer_sequencer #(
    parameter int DEPTH         = 249,
    parameter int READ_LATENCY  = 2,
    parameter int DEF_RATE_INT  = 256,
    parameter int DEF_RATE_PHS  = 256,
    parameter int DEF_STEPS_INT = 10,
    parameter int DEF_STEPS_PHS = 40
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CFG_UPDATE,
    input  logic [15:0] CFG_RATE_INT,
    input  logic [15:0] CFG_RATE_PHS,
    input  logic [15:0] CFG_STEPS_INT,
    input  logic [15:0] CFG_STEPS_PHS,
    input  logic        CFG_FIXED,
    input  logic        OVERRUN_CLR,
    output logic        RD_EN,
    output logic [7:0]  ADDR,
    input  logic [15:0] RDATA_INTENSITY,
    input  logic [7:0]  RDATA_PHASE,
    output logic        DIN_VALID,
    output logic [15:0] INTENSITY_IN,
    output logic [7:0]  PHASE_IN,
    output logic [15:0] UPDATE_RATE_INTENSITY,
    output logic [15:0] UPDATE_RATE_PHASE,
    output logic [15:0] COMPLETION_STEPS_INTENSITY,
    output logic [15:0] COMPLETION_STEPS_PHASE,
    output logic        FIXED_COMPLETION_STEPS,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        OVERRUN
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // ADDR is only 8 bits wide and the delay line needs at least one stage.
    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("silencer_sequencer: DEPTH must be in 1..256");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("silencer_sequencer: READ_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0] rate_int;
        logic [15:0] rate_phs;
        logic [15:0] steps_int;
        logic [15:0] steps_phs;
        logic        fixed;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        rate_int:  16'(DEF_RATE_INT),
        rate_phs:  16'(DEF_RATE_PHS),
        steps_int: 16'(DEF_STEPS_INT),
        steps_phs: 16'(DEF_STEPS_PHS),
        fixed:     1'b0
    };

    // The silencer divides by these values, so zero is never allowed through.
    function automatic logic [15:0] nonzero(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] last_q, last_d;
    cfg_t                    pend_cfg_q, pend_cfg_d;
    cfg_t                    act_cfg_q, act_cfg_d;
    logic                    rd_en;
    logic                    addr_last;

    assign addr_last = (addr_q == AW'(DEPTH - 1));

    // Next-state logic: frame sequencing, shadow capture, early-START queueing
    // and the valid/last delay lines that line DIN_VALID up with RDATA.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        pend_cfg_d = pend_cfg_q;
        act_cfg_d  = act_cfg_q;
        rd_en      = 1'b0;

        if (CFG_UPDATE) begin
            pend_cfg_d.rate_int  = nonzero(CFG_RATE_INT);
            pend_cfg_d.rate_phs  = nonzero(CFG_RATE_PHS);
            pend_cfg_d.steps_int = nonzero(CFG_STEPS_INT);
            pend_cfg_d.steps_phs = nonzero(CFG_STEPS_PHS);
            pend_cfg_d.fixed     = CFG_FIXED;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The queued request is consumed here; a START in this very
                // cycle becomes the request for the following frame.
                act_cfg_d = pend_cfg_q;
                pending_d = START;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                rd_en = 1'b1;
                if (addr_last) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(READ_LATENCY - 1)) begin
                    drain_d = '0;
                    state_d = (pending_q || START) ? ST_LOAD : ST_IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear first so that a simultaneous new overrun wins.
        if (OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
        if (START && (state_q == ST_ISSUE || state_q == ST_DRAIN)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        vld_d[0]  = rd_en;
        last_d[0] = rd_en && addr_last;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // State registers with synchronous reset; reset also flushes the delay
    // lines so an aborted burst stops producing DIN_VALID immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            drain_q    <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            vld_q      <= '0;
            last_q     <= '0;
            pend_cfg_q <= CFG_DEFAULT;
            act_cfg_q  <= CFG_DEFAULT;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            pend_cfg_q <= pend_cfg_d;
            act_cfg_q  <= act_cfg_d;
        end
    end

    assign RD_EN                      = rd_en;
    assign ADDR                       = 8'(addr_q);
    assign DIN_VALID                  = vld_q[READ_LATENCY-1];
    assign FRAME_DONE                 = last_q[READ_LATENCY-1];
    assign INTENSITY_IN               = RDATA_INTENSITY;
    assign PHASE_IN                   = RDATA_PHASE;
    assign UPDATE_RATE_INTENSITY      = act_cfg_q.rate_int;
    assign UPDATE_RATE_PHASE          = act_cfg_q.rate_phs;
    assign COMPLETION_STEPS_INTENSITY = act_cfg_q.steps_int;
    assign COMPLETION_STEPS_PHASE     = act_cfg_q.steps_phs;
    assign FIXED_COMPLETION_STEPS     = act_cfg_q.fixed;
    assign BUSY                       = (state_q != ST_IDLE);
    assign OVERRUN                    = overrun_q;

endmodule

// File: tb/tb_silencer_sequencer.sv
// tb_silencer_sequencer
//   Self-checking bench for silencer_sequencer. A drive-memory model with a
//   two-cycle read latency feeds the DUT; every accepted frame pushes its
//   expected beats into a scoreboard that a negedge monitor pops on DIN_VALID.
//   Scenario tasks check timing, settings double-buffering, queueing/overrun
//   and reset abort.
module tb_silencer_sequencer;

    localparam int DEPTH = 249;
    localparam int RL    = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CFG_UPDATE = 1'b0;
    logic [15:0] CFG_RATE_INT = 16'd256;
    logic [15:0] CFG_RATE_PHS = 16'd256;
    logic [15:0] CFG_STEPS_INT = 16'd10;
    logic [15:0] CFG_STEPS_PHS = 16'd40;
    logic        CFG_FIXED = 1'b0;
    logic        OVERRUN_CLR = 1'b0;
    logic        RD_EN;
    logic [7:0]  ADDR;
    logic [15:0] RDATA_INTENSITY;
    logic [7:0]  RDATA_PHASE;
    logic        DIN_VALID;
    logic [15:0] INTENSITY_IN;
    logic [7:0]  PHASE_IN;
    logic [15:0] UPDATE_RATE_INTENSITY;
    logic [15:0] UPDATE_RATE_PHASE;
    logic [15:0] COMPLETION_STEPS_INTENSITY;
    logic [15:0] COMPLETION_STEPS_PHASE;
    logic        FIXED_COMPLETION_STEPS;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        OVERRUN;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    typedef struct {
        logic [15:0] i;
        logic [7:0]  p;
        logic        last;
    } beat_t;

    beat_t sb[$];

    silencer_sequencer #(
        .DEPTH(DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .CFG_UPDATE(CFG_UPDATE),
        .CFG_RATE_INT(CFG_RATE_INT),
        .CFG_RATE_PHS(CFG_RATE_PHS),
        .CFG_STEPS_INT(CFG_STEPS_INT),
        .CFG_STEPS_PHS(CFG_STEPS_PHS),
        .CFG_FIXED(CFG_FIXED),
        .OVERRUN_CLR(OVERRUN_CLR),
        .RD_EN(RD_EN),
        .ADDR(ADDR),
        .RDATA_INTENSITY(RDATA_INTENSITY),
        .RDATA_PHASE(RDATA_PHASE),
        .DIN_VALID(DIN_VALID),
        .INTENSITY_IN(INTENSITY_IN),
        .PHASE_IN(PHASE_IN),
        .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY),
        .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
        .COMPLETION_STEPS_INTENSITY(COMPLETION_STEPS_INTENSITY),
        .COMPLETION_STEPS_PHASE(COMPLETION_STEPS_PHASE),
        .FIXED_COMPLETION_STEPS(FIXED_COMPLETION_STEPS),
        .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Drive-memory contents, a fixed function of the address.
    function automatic logic [15:0] mem_int(input int a);
        return 16'(32'hA500 ^ (a * 37));
    endfunction

    function automatic logic [7:0] mem_phs(input int a);
        return 8'(a * 3 + 1);
    endfunction

    // Two-stage read pipeline; data is zero unless RD_EN was high, so any
    // misalignment of DIN_VALID shows up as wrong data.
    logic [15:0] mi_s0, mi_s1;
    logic [7:0]  mp_s0, mp_s1;
    always @(posedge CLK) begin
        mi_s0 <= RD_EN ? mem_int(int'(ADDR)) : 16'h0000;
        mp_s0 <= RD_EN ? mem_phs(int'(ADDR)) : 8'h00;
        mi_s1 <= mi_s0;
        mp_s1 <= mp_s0;
    end
    assign RDATA_INTENSITY = mi_s1;
    assign RDATA_PHASE     = mp_s1;

    // Scoreboard monitor: each DIN_VALID beat must match the oldest expected
    // beat, and FRAME_DONE must never appear outside a valid beat.
    always @(negedge CLK) begin
        if (mon_en) begin
            tests_run++;
            if (DIN_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_beat: DIN_VALID=1 got int=%h phs=%h, want no beat", INTENSITY_IN, PHASE_IN);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if (INTENSITY_IN !== e.i || PHASE_IN !== e.p || FRAME_DONE !== e.last) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_beat: got int=%h phs=%h done=%b, want int=%h phs=%h done=%b",
                                 INTENSITY_IN, PHASE_IN, FRAME_DONE, e.i, e.p, e.last);
                    end
                end
            end else if (FRAME_DONE !== 1'b0 || DIN_VALID !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_flags: got DIN_VALID=%b FRAME_DONE=%b, want 0/0", DIN_VALID, FRAME_DONE);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_frame();
        for (int a = 0; a < DEPTH; a++) begin
            beat_t b;
            b.i    = mem_int(a);
            b.p    = mem_phs(a);
            b.last = (a == DEPTH - 1);
            sb.push_back(b);
        end
    endtask

    // Called at a negedge; START covers exactly one posedge and the task
    // returns at the negedge of the LOAD cycle.
    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (BUSY === 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({RD_EN, DIN_VALID, BUSY, FRAME_DONE, OVERRUN} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got RD_EN,DIN_VALID,BUSY,FRAME_DONE,OVERRUN=%b, want 00000",
                     {RD_EN, DIN_VALID, BUSY, FRAME_DONE, OVERRUN});
        end
        tests_run++;
        if (ADDR !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr: got %0d, want 0", ADDR);
        end
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'd256 || UPDATE_RATE_PHASE !== 16'd256) begin
            tests_failed++;
            $display("[TB] FAIL reset_rates: got %0d/%0d, want 256/256", UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE);
        end
        tests_run++;
        if (COMPLETION_STEPS_INTENSITY !== 16'd10 || COMPLETION_STEPS_PHASE !== 16'd40) begin
            tests_failed++;
            $display("[TB] FAIL reset_steps: got %0d/%0d, want 10/40", COMPLETION_STEPS_INTENSITY, COMPLETION_STEPS_PHASE);
        end
        tests_run++;
        if (FIXED_COMPLETION_STEPS !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fixed: got %b, want 0", FIXED_COMPLETION_STEPS);
        end
        mon_en = 1'b1;
    endtask

    // START sampled at edge k; iteration j observes cycle k+j.
    task automatic test_single_frame();
        repeat (6) @(negedge CLK);
        push_frame();
        pulse_start();
        for (int j = 1; j <= DEPTH + 6; j++) begin
            logic [3:0] want;
            want = {(j >= 2 && j <= DEPTH + 1), (j >= 4 && j <= DEPTH + 3), (j <= DEPTH + 3), (j == DEPTH + 3)};
            tests_run++;
            if ({RD_EN, DIN_VALID, BUSY, FRAME_DONE} !== want) begin
                tests_failed++;
                $display("[TB] FAIL frame_timing j=%0d: got RD_EN,DIN_VALID,BUSY,FRAME_DONE=%b, want %b",
                         j, {RD_EN, DIN_VALID, BUSY, FRAME_DONE}, want);
            end
            if (want[3]) begin
                tests_run++;
                if (ADDR !== 8'(j - 2)) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_addr j=%0d: got %0d, want %0d", j, ADDR, j - 2);
                end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_cfg_midburst();
        bit ok;
        bit changed = 1'b0;
        push_frame();
        pulse_start();
        repeat (30) @(negedge CLK);
        CFG_RATE_INT = 16'h0010;
        CFG_UPDATE   = 1'b1;
        @(negedge CLK);
        CFG_UPDATE   = 1'b0;
        for (int i = 0; i < 400 && BUSY === 1'b1; i++) begin
            if (UPDATE_RATE_INTENSITY !== 16'd256) changed = 1'b1;
            @(negedge CLK);
        end
        tests_run++;
        if (changed || BUSY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cfg_midburst_hold: got changed=%b busy=%b, want 0/0", changed, BUSY);
        end
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'd256) begin
            tests_failed++;
            $display("[TB] FAIL cfg_idle_hold: got %h, want 0100", UPDATE_RATE_INTENSITY);
        end
        push_frame();
        pulse_start();
        @(negedge CLK);
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'h0010) begin
            tests_failed++;
            $display("[TB] FAIL cfg_applied: got %h, want 0010", UPDATE_RATE_INTENSITY);
        end
        wait_idle(400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL cfg_idle_timeout: got BUSY=%b, want 0", BUSY);
        end
    endtask

    // CFG_UPDATE and START in the same IDLE cycle, with zero values clamped.
    task automatic test_zero_clamp();
        bit ok;
        CFG_RATE_INT  = 16'd0;
        CFG_RATE_PHS  = 16'h0123;
        CFG_STEPS_INT = 16'd7;
        CFG_STEPS_PHS = 16'd0;
        CFG_FIXED     = 1'b1;
        CFG_UPDATE    = 1'b1;
        push_frame();
        pulse_start();
        CFG_UPDATE    = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'd1 || UPDATE_RATE_PHASE !== 16'h0123) begin
            tests_failed++;
            $display("[TB] FAIL clamp_rates: got %h/%h, want 0001/0123", UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE);
        end
        tests_run++;
        if (COMPLETION_STEPS_INTENSITY !== 16'd7 || COMPLETION_STEPS_PHASE !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL clamp_steps: got %0d/%0d, want 7/1", COMPLETION_STEPS_INTENSITY, COMPLETION_STEPS_PHASE);
        end
        tests_run++;
        if (FIXED_COMPLETION_STEPS !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clamp_fixed: got %b, want 1", FIXED_COMPLETION_STEPS);
        end
        wait_idle(400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL clamp_idle_timeout: got BUSY=%b, want 0", BUSY);
        end
    endtask

    task automatic test_back_to_back();
        int rd_cnt = 0, fd_cnt = 0, first2 = 0, busy_low = 0;
        bit ov = 1'b0;
        push_frame();
        pulse_start();
        for (int j = 1; j <= 2 * DEPTH + 10; j++) begin
            if (RD_EN === 1'b1) rd_cnt++;
            if (RD_EN === 1'b1 && first2 == 0 && j > DEPTH + 1) first2 = j;
            if (BUSY !== 1'b1 && busy_low == 0) busy_low = j;
            if (FRAME_DONE === 1'b1) fd_cnt++;
            if (OVERRUN !== 1'b0) ov = 1'b1;
            START = (j == 90);
            if (j == 90) push_frame();
            @(negedge CLK);
        end
        tests_run++;
        if (rd_cnt != 2 * DEPTH || fd_cnt != 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_counts: got rd=%0d done=%0d, want %0d/2", rd_cnt, fd_cnt, 2 * DEPTH);
        end
        tests_run++;
        if (first2 != DEPTH + 5) begin
            tests_failed++;
            $display("[TB] FAIL b2b_gap: got second burst at j=%0d, want %0d", first2, DEPTH + 5);
        end
        tests_run++;
        if (busy_low != 2 * DEPTH + 7) begin
            tests_failed++;
            $display("[TB] FAIL b2b_busy: got BUSY low at j=%0d, want %0d", busy_low, 2 * DEPTH + 7);
        end
        tests_run++;
        if (ov) begin
            tests_failed++;
            $display("[TB] FAIL b2b_overrun: got OVERRUN=1, want 0");
        end
    endtask

    task automatic test_overrun();
        int rd_cnt = 0, fd_cnt = 0;
        logic ov50 = 1'bx, ov51 = 1'bx, ov61 = 1'bx;
        bit ok;
        push_frame();
        pulse_start();
        for (int j = 1; j <= 2 * DEPTH + 10; j++) begin
            if (RD_EN === 1'b1) rd_cnt++;
            if (FRAME_DONE === 1'b1) fd_cnt++;
            if (j == 50) ov50 = OVERRUN;
            if (j == 51) ov51 = OVERRUN;
            if (j == 61) ov61 = OVERRUN;
            START       = (j == 40 || j == 50 || j == 60);
            OVERRUN_CLR = (j == 60);
            if (j == 40) push_frame();
            @(negedge CLK);
        end
        wait_idle(20, ok);
        tests_run++;
        if (ov50 !== 1'b0 || ov51 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_set: got OVERRUN %b then %b, want 0 then 1", ov50, ov51);
        end
        tests_run++;
        if (ov61 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_set_wins: got %b, want 1", ov61);
        end
        tests_run++;
        if (rd_cnt != 2 * DEPTH || fd_cnt != 2 || !ok) begin
            tests_failed++;
            $display("[TB] FAIL overrun_bursts: got rd=%0d done=%0d idle=%b, want %0d/2/1", rd_cnt, fd_cnt, ok, 2 * DEPTH);
        end
        tests_run++;
        if (OVERRUN !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_sticky: got %b, want 1", OVERRUN);
        end
        OVERRUN_CLR = 1'b1;
        @(negedge CLK);
        OVERRUN_CLR = 1'b0;
        tests_run++;
        if (OVERRUN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overrun_clear: got %b, want 0", OVERRUN);
        end
    endtask

    task automatic test_reset_midburst();
        bit found = 1'b0;
        bit ok;
        push_frame();
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            if (RD_EN === 1'b1 && ADDR === 8'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL abort_reach: got ADDR=%0d, want 100 within budget", ADDR);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        tests_run++;
        if ({RD_EN, DIN_VALID, BUSY, FRAME_DONE} !== 4'b0 || ADDR !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_flags: got RD_EN,DIN_VALID,BUSY,FRAME_DONE=%b ADDR=%0d, want 0000/0",
                     {RD_EN, DIN_VALID, BUSY, FRAME_DONE}, ADDR);
        end
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'd256 || UPDATE_RATE_PHASE !== 16'd256 ||
            COMPLETION_STEPS_INTENSITY !== 16'd10 || COMPLETION_STEPS_PHASE !== 16'd40 ||
            FIXED_COMPLETION_STEPS !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_settings: got %0d/%0d/%0d/%0d/%b, want 256/256/10/40/0",
                     UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE, COMPLETION_STEPS_INTENSITY,
                     COMPLETION_STEPS_PHASE, FIXED_COMPLETION_STEPS);
        end
        sb.delete();
        repeat (10) @(negedge CLK);
        // The pending shadow must also have been reloaded with defaults.
        push_frame();
        pulse_start();
        @(negedge CLK);
        tests_run++;
        if (UPDATE_RATE_INTENSITY !== 16'd256 || COMPLETION_STEPS_PHASE !== 16'd40 || FIXED_COMPLETION_STEPS !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_pending_shadow: got %0d/%0d/%b, want 256/40/0",
                     UPDATE_RATE_INTENSITY, COMPLETION_STEPS_PHASE, FIXED_COMPLETION_STEPS);
        end
        wait_idle(400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle_timeout: got BUSY=%b, want 0", BUSY);
        end
    endtask

    // Scenario sequence followed by the final scoreboard drain check.
    initial begin
        test_reset();
        test_single_frame();
        test_cfg_midburst();
        test_zero_clamp();
        test_back_to_back();
        test_overrun();
        test_reset_midburst();
        repeat (5) @(negedge CLK);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_drained: got %0d beats outstanding, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
